rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Write-side front end of the register file: merges writeback results from the in-order pipeline and from the multi-cycle multiply/divide unit (MDU) onto the single RF write port (RFWr/WrDtAdr/WrDt).
- Buffers MDU results in a small FIFO.
- Keeps a busy scoreboard of registers with an outstanding MDU result, so decode can stall RAW/WAW hazards.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, >=2).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- pipe_wr_en  input  1  pipeline WB stage writes this cycle; always accepted, no backpressure.
- pipe_rd  input  5  pipeline destination register.
- pipe_data  input  32  pipeline write data.
- mdu_issue  input  1  MDU op issued this cycle; reserves mdu_issue_rd.
- mdu_issue_rd  input  5  destination register of the issued MDU op.
- mdu_valid  input  1  MDU result available.
- mdu_ready  output  1  FIFO can accept an MDU result.
- mdu_rd  input  5  MDU result destination.
- mdu_data  input  32  MDU result data.
- q_rs1  input  5  decode query address, source 1.
- q_rs2  input  5  decode query address, source 2.
- q_rd  input  5  decode query address, destination.
- rs1_busy  output  1  q_rs1 has a pending MDU write (combinational).
- rs2_busy  output  1  q_rs2 has a pending MDU write (combinational).
- rd_busy  output  1  q_rd has a pending MDU write (combinational).
- RFWr  output  1  RF write enable, registered.
- WrDtAdr  output  5  RF write address, registered.
- WrDt  output  32  RF write data, registered.

Behaviour:
- Reset (rst=1 at posedge): RFWr=0, WrDtAdr=0, WrDt=0; FIFO empty (count=0, pointers 0); busy_mask=0. mdu_ready=1 after reset. Reset overrides all same-cycle pushes, issues and writes.
- mdu_ready = (count < DEPTH), based on current count only. A full FIFO does not accept even if it pops in the same cycle.
- Push: when mdu_valid && mdu_ready, {mdu_rd, mdu_data} is written at the write pointer. The write pointer wraps modulo DEPTH.
- Selection each cycle (priority order):
  1. pipe_wr_en=1: the output register loads {1, pipe_rd, pipe_data}. The FIFO does not pop.
  2. Otherwise, FIFO non-empty: pop the head and load {1, head_rd, head_data}. The read pointer wraps.
  3. Otherwise, load RFWr=0. WrDtAdr/WrDt hold their previous values.
- Latency: an accepted write reaches the RF outputs one cycle later. An MDU result pushed into an empty FIFO with no pipeline write appears at the earliest on the cycle after the push. There is no same-cycle bypass from push to pop.
- x0 handling: any selected write with rd=0 loads RFWr=0. A FIFO entry with rd=0 is still popped and discarded.
- count update: +1 on push only; -1 on pop only; unchanged when both or neither occur.
- Scoreboard:
  - mdu_issue with mdu_issue_rd!=0 sets busy_mask[mdu_issue_rd]; rd=0 is ignored.
  - A FIFO pop clears busy_mask[head_rd] on the same edge that RFWr rises for that entry.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Busy queries: rsN_busy = busy_mask[q_rsN]; rd_busy = busy_mask[q_rd]. Index 0 always reads 0.
- Ordering contract: decode stalls any instruction whose rs1/rs2/rd is busy, so pipeline writes never target a busy register. The block does not reorder or check this.
- A pipeline write never stalls. Under a continuous pipeline write stream the FIFO fills, and mdu_ready=0 backpressures the MDU.

Test Plan:
- Reset: hold rst=1 two cycles with mdu_valid=1, pipe_wr_en=1 -> RFWr=0, mdu_ready=1, all busy=0, FIFO empty after release.
- Pipeline only: pipe_wr_en=1, rd=5, data=0xDEADBEEF at cycle N -> cycle N+1: RFWr=1, WrDtAdr=5, WrDt=0xDEADBEEF; cycle N+2 with pipe_wr_en=0: RFWr=0.
- MDU path and scoreboard:
  - mdu_issue rd=7 -> q_rs1=7 gives rs1_busy=1 next cycle.
  - mdu_valid rd=7, data=0x12345678 -> next cycle RFWr=1, addr 7, data 0x12345678; rs1_busy drops on that same edge.
- Priority and backpressure (DEPTH=2):
  - pipe_wr_en held 4 cycles while MDU pushes rd=3, then rd=4 -> mdu_ready=0 after two pushes; RF sees only pipeline writes.
  - Then pipe_wr_en=0 -> x3 written, then x4 on consecutive cycles; mdu_ready returns to 1 after the first pop.
- x0 discard: MDU result rd=0, data=0xFFFFFFFF -> popped, RFWr stays 0, count returns to 0; mdu_issue rd=0 leaves busy_mask=0.
- Set/clear collision: FIFO head rd=9 pops in the same cycle as mdu_issue rd=9 -> x9 written, busy_mask[9] remains 1.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write port front end: merges pipeline writeback with buffered
// MDU results and tracks registers that still await an MDU write.
module rf_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wr_en,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_rd,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  input  logic [4:0]  q_rd,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rd_busy,
  output logic        RFWr,
  output logic [4:0]  WrDtAdr,
  output logic [31:0] WrDt
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic [31:0]   busy_q, busy_d;
  logic          wr_q;
  logic [4:0]    adr_q;
  logic [31:0]   dt_q;

  logic       push, pop;
  logic [4:0] head_rd;

  // MDU handshake: a result transfers on a clock edge where mdu_valid and
  // mdu_ready are both high; mdu_ready depends only on the current fill level.
  assign mdu_ready = (count_q < FULL_CNT);
  assign push      = mdu_valid && mdu_ready;
  assign pop       = !pipe_wr_en && (count_q != '0);
  assign head_rd   = fifo_rd_q[rd_ptr_q];

  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_rd] = 1'b0;
    // Issue is applied after the clear so a same-cycle set wins.
    if (mdu_issue && (mdu_issue_rd != 5'd0)) busy_d[mdu_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_rd_q[wr_ptr_q]   <= mdu_rd;
      fifo_data_q[wr_ptr_q] <= mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= 1'b0;
      adr_q    <= 5'd0;
      dt_q     <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= 32'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pipe_wr_en) begin
        wr_q  <= (pipe_rd != 5'd0);
        adr_q <= pipe_rd;
        dt_q  <= pipe_data;
      end else if (pop) begin
        wr_q     <= (head_rd != 5'd0);
        adr_q    <= head_rd;
        dt_q     <= fifo_data_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end else begin
        wr_q <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = busy_q[q_rs1] && (q_rs1 != 5'd0);
  assign rs2_busy = busy_q[q_rs2] && (q_rs2 != 5'd0);
  assign rd_busy  = busy_q[q_rd]  && (q_rd  != 5'd0);

  assign RFWr    = wr_q;
  assign WrDtAdr = adr_q;
  assign WrDt    = dt_q;
endmodule
